// File: rtl/pll_seq_pkg.sv
// Shared types, default timing and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    HOLD_SYS  = 3'd2,
    HOLD_CPU  = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam int unsigned DEF_LOCK_STABLE = 1024;
  localparam int unsigned DEF_SYS_HOLD    = 256;
  localparam int unsigned DEF_CPU_HOLD    = 4096;
  localparam int unsigned DEF_CE_DIV      = 5;
  localparam int unsigned DEF_CE_SUB      = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Bits needed to hold 0..max(a,b,c)-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Clock-enable generator: ce_32m every CE_DIV cycles, ce_8m on every
// CE_SUB-th ce_32m. i_en is the value sys_reset_n takes on the coming edge,
// so the strobes drop on the same edge as sys_reset_n.
module ce_divider
  import pll_seq_pkg::*;
#(
  parameter int unsigned CE_DIV = DEF_CE_DIV,
  parameter int unsigned CE_SUB = DEF_CE_SUB
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_ce_32m,
  output logic o_ce_8m
);

  localparam int unsigned DW = cnt_width(CE_DIV, 1, 1);
  localparam int unsigned SW = cnt_width(CE_SUB, 1, 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(CE_SUB - 1);

  logic          r_en_d;
  logic [DW-1:0] r_div;
  logic [SW-1:0] r_sub;
  logic          r_ce_32m;
  logic          r_ce_8m;

  // Divider and sub-divider; counting starts the cycle after release so the
  // first ce_32m lands CE_DIV cycles after sys_reset_n rises.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_en_d   <= 1'b0;
      r_div    <= '0;
      r_sub    <= '0;
      r_ce_32m <= 1'b0;
      r_ce_8m  <= 1'b0;
    end else begin
      r_en_d <= i_en;
      if (!i_en) begin
        r_div    <= '0;
        r_sub    <= '0;
        r_ce_32m <= 1'b0;
        r_ce_8m  <= 1'b0;
      end else if (r_en_d && (r_div == DIV_LAST)) begin
        r_div    <= '0;
        r_ce_32m <= 1'b1;
        if (r_sub == SUB_LAST) begin
          r_sub   <= '0;
          r_ce_8m <= 1'b1;
        end else begin
          r_sub   <= r_sub + 1'b1;
          r_ce_8m <= 1'b0;
        end
      end else begin
        if (r_en_d) r_div <= r_div + 1'b1;
        r_ce_32m <= 1'b0;
        r_ce_8m  <= 1'b0;
      end
    end
  end

  assign o_ce_32m = r_ce_32m;
  assign o_ce_8m  = r_ce_8m;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and reset sequencer with clock-enable generation.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   WAIT_LOCK | waiting for synchronised lock; all resets asserted
//   STABILIZE | lock must stay high LOCK_STABLE consecutive cycles
//   HOLD_SYS  | lock qualified; sys_reset_n held low SYS_HOLD cycles
//   HOLD_CPU  | sys released, strobes running; cpu held CPU_HOLD cycles
//   RUN       | everything released; ready high
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int unsigned SYS_HOLD    = DEF_SYS_HOLD,
  parameter int unsigned CPU_HOLD    = DEF_CPU_HOLD,
  parameter int unsigned CE_DIV      = DEF_CE_DIV,
  parameter int unsigned CE_SUB      = DEF_CE_SUB,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  output logic       sys_reset_n,
  output logic       cpu_reset_n,
  output logic       ce_32m,
  output logic       ce_8m,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CW = cnt_width(LOCK_STABLE, SYS_HOLD, CPU_HOLD);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] SYS_LAST    = CW'(SYS_HOLD - 1);
  localparam logic [CW-1:0] CPU_LAST    = CW'(CPU_HOLD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_sys_rel;
  logic                   r_cpu_rel;
  logic                   w_sys_rel_nxt;
  logic                   w_cpu_rel_nxt;
  logic                   w_loss;
  logic [7:0]             r_loss_cnt;
  logic                   w_ce_32m;
  logic                   w_ce_8m;

  // Lock synchroniser; SYNC_STAGES must be at least 2.
  always_ff @(posedge clk) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Next state and shared counter; lock loss takes priority over completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      WAIT_LOCK: if (w_lock_s) w_state_nxt = STABILIZE;
      STABILIZE: begin
        if (!w_lock_s)                 w_state_nxt = WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_state_nxt = HOLD_SYS;
        else                           w_cnt_nxt   = r_cnt + 1'b1;
      end
      HOLD_SYS: begin
        if (!w_lock_s)              w_state_nxt = WAIT_LOCK;
        else if (r_cnt == SYS_LAST) w_state_nxt = HOLD_CPU;
        else                        w_cnt_nxt   = r_cnt + 1'b1;
      end
      HOLD_CPU: begin
        if (!w_lock_s)              w_state_nxt = WAIT_LOCK;
        else if (r_cnt == CPU_LAST) w_state_nxt = RUN;
        else                        w_cnt_nxt   = r_cnt + 1'b1;
      end
      RUN:     if (!w_lock_s) w_state_nxt = WAIT_LOCK;
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  assign w_sys_rel_nxt = (w_state_nxt == HOLD_CPU) || (w_state_nxt == RUN);
  assign w_cpu_rel_nxt = (w_state_nxt == RUN);
  assign w_loss        = (r_state == RUN) && !w_lock_s;

  // State, counter and registered reset outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= WAIT_LOCK;
      r_cnt     <= '0;
      r_sys_rel <= 1'b0;
      r_cpu_rel <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sys_rel <= w_sys_rel_nxt;
      r_cpu_rel <= w_cpu_rel_nxt;
    end
  end

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk) begin
    if (!reset_n)                            r_loss_cnt <= 8'd0;
    else if (w_loss && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  ce_divider #(
    .CE_DIV (CE_DIV),
    .CE_SUB (CE_SUB)
  ) u_ce_divider (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (w_sys_rel_nxt),
    .o_ce_32m (w_ce_32m),
    .o_ce_8m  (w_ce_8m)
  );

  assign sys_reset_n   = r_sys_rel;
  assign cpu_reset_n   = r_cpu_rel;
  assign ready         = r_cpu_rel;
  assign ce_32m        = w_ce_32m;
  assign ce_8m         = w_ce_8m;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a default-parameter instance plus a
// short-timing instance used for the lock-loss saturation run.
module tb_pll_reset_sequencer;

  localparam int S_LS = 4;
  localparam int S_SH = 3;
  localparam int S_CH = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       pll_lock;
  logic       pll_lock_b;
  logic       sys_reset_n, cpu_reset_n, ce_32m, ce_8m, ready;
  logic [7:0] lock_loss_cnt;
  logic       sys_b, cpu_b, ce32_b, ce8_b, ready_b;
  logic [7:0] llc_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pll_reset_sequencer u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_lock      (pll_lock),
    .sys_reset_n   (sys_reset_n),
    .cpu_reset_n   (cpu_reset_n),
    .ce_32m        (ce_32m),
    .ce_8m         (ce_8m),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  pll_reset_sequencer #(
    .LOCK_STABLE (S_LS),
    .SYS_HOLD    (S_SH),
    .CPU_HOLD    (S_CH)
  ) u_dut_s (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_lock      (pll_lock_b),
    .sys_reset_n   (sys_b),
    .cpu_reset_n   (cpu_b),
    .ce_32m        (ce32_b),
    .ce_8m         (ce8_b),
    .ready         (ready_b),
    .lock_loss_cnt (llc_b)
  );

  // Model: outputs follow from h, the number of consecutive edges at which
  // the (2-cycle delayed) lock has been seen high since the last drop/reset.
  int m_h[2];
  int m_llc[2];
  bit m_d0[2];
  bit m_d1[2];

  function automatic int sys_at(input int i);
    return (i == 0) ? (1 + 1024 + 256) : (1 + S_LS + S_SH);
  endfunction

  function automatic int run_at(input int i);
    return (i == 0) ? (1 + 1024 + 256 + 4096) : (1 + S_LS + S_SH + S_CH);
  endfunction

  always @(posedge clk) begin
    bit ls, lin;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      ls  = m_d1[i];
      lin = (i == 0) ? pll_lock : pll_lock_b;
      if (!reset_n) begin
        m_h[i] = 0; m_llc[i] = 0; m_d0[i] = 0; m_d1[i] = 0;
      end else begin
        if (ls) m_h[i]++;
        else begin
          if (m_h[i] >= run_at(i) && m_llc[i] < 255) m_llc[i]++;
          m_h[i] = 0;
        end
        m_d1[i] = m_d0[i];
        m_d0[i] = lin;
      end
    end
  end

  function automatic logic [12:0] exp_vec(input int i);
    int k;
    logic s, c, e32, e8;
    s   = (m_h[i] >= sys_at(i));
    c   = (m_h[i] >= run_at(i));
    k   = m_h[i] - sys_at(i);
    e32 = (k > 0) && (k % 5 == 0);
    e8  = (k > 0) && (k % 20 == 0);
    return {s, c, e32, e8, c, 8'(m_llc[i])};
  endfunction

  function automatic logic [12:0] act_vec(input int i);
    if (i == 0) return {sys_reset_n, cpu_reset_n, ce_32m, ce_8m, ready, lock_loss_cnt};
    return {sys_b, cpu_b, ce32_b, ce8_b, ready_b, llc_b};
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [12:0] a, e;
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        a = act_vec(i);
        e = exp_vec(i);
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL model_cmp inst=%0d cyc=%0d actual=%h required=%h {sys,cpu,ce32,ce8,ready,cnt}",
                   i, cyc, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic logic main_sig(input int sel);
    case (sel)
      0:       return sys_reset_n;
      1:       return cpu_reset_n;
      default: return ready;
    endcase
  endfunction

  // Returns the edge number after which the selected output is first high, -1 on timeout.
  task automatic wait_sig(input int sel, input int bound, output int at);
    at = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (main_sig(sel)) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t, tr, t0, g, r, n8bad, n8on;
    int t32[$];
    int t8[$];
    reset_n    = 1'b0;
    pll_lock   = 1'b0;
    pll_lock_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sys", sys_reset_n, 0);
    chk("reset_cpu", cpu_reset_n, 0);
    chk("reset_ready", ready, 0);
    chk("reset_ce", {ce_32m, ce_8m}, 0);
    chk("reset_cnt", lock_loss_cnt, 0);
    reset_n = 1'b1;

    // Clean start: lock rises just after edge 10.
    while (cyc < 10) @(negedge clk);
    pll_lock = 1'b1;
    wait_sig(0, 2000, t);
    chk("clean_sys_rise", t, 1293);
    wait_sig(1, 5000, t);
    chk("clean_cpu_rise", t, 1293 + 4096);
    chk("clean_ready", ready, 1);

    // Strobe cadence over 100 ce_32m pulses.
    n8bad = 0;
    for (int n = 0; n < 2000 && t32.size() < 100; n++) begin
      @(negedge clk);
      if (ce_32m) t32.push_back(cyc);
      if (ce_8m) begin
        t8.push_back(cyc);
        if (!ce_32m) n8bad++;
      end
    end
    chk("ce32_count", t32.size(), 100);
    for (int j = 1; j < t32.size(); j++) chk("ce32_spacing", t32[j] - t32[j-1], 5);
    chk("ce8_count", t8.size(), 25);
    chk("ce8_not_on_ce32", n8bad, 0);
    for (int j = 1; j < t8.size(); j++) chk("ce8_spacing", t8[j] - t8[j-1], 20);
    n8on = 0;
    for (int j = 0; j < t32.size(); j++) if ((t32[j] - t8[0]) % 20 == 0) n8on++;
    chk("ce8_every_4th", n8on, 25);

    // Reset, then a one-cycle glitch during STABILIZE.
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    g = cyc;
    pll_lock = 1'b1;
    while (cyc < g + 500) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    tr = cyc;
    wait_sig(0, 3000, t);
    chk("glitch_sys_rise", t, tr + 1283);
    chk("glitch_cnt", lock_loss_cnt, 0);
    wait_sig(1, 5000, t);
    chk("glitch_cpu_rise", t, tr + 1283 + 4096);

    // Lock loss in RUN for 50 cycles.
    @(negedge clk);
    t0 = cyc;
    pll_lock = 1'b0;
    while (cyc < t0 + 2) @(negedge clk);
    chk("loss_still_ready", {sys_reset_n, cpu_reset_n, ready}, 3'b111);
    @(negedge clk);
    chk("loss_all_low", {sys_reset_n, cpu_reset_n, ready, ce_32m, ce_8m}, 0);
    chk("loss_cnt_1", lock_loss_cnt, 1);
    while (cyc < t0 + 50) @(negedge clk);
    pll_lock = 1'b1;
    tr = cyc;
    wait_sig(0, 3000, t);
    chk("relock_sys_rise", t, tr + 1283);

    // Reset in HOLD_CPU.
    repeat (100) @(negedge clk);
    chk("holdcpu_cpu_low", cpu_reset_n, 0);
    r = cyc;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_sys_low", sys_reset_n, 0);
    chk("midreset_cnt_clr", lock_loss_cnt, 0);
    reset_n = 1'b1;
    wait_sig(0, 3000, t);
    chk("midreset_sys_rise", t, r + 1 + 1283);

    // Saturation on the short-timing instance.
    for (int ev = 1; ev <= 300; ev++) begin
      pll_lock_b = 1'b1;
      repeat (20) @(negedge clk);
      if (ev == 1) chk("sat_ready_first", ready_b, 1);
      pll_lock_b = 1'b0;
      repeat (4) @(negedge clk);
      if (ev == 10) chk("sat_cnt_10", llc_b, 10);
    end
    chk("sat_cnt_255", llc_b, 255);
    reset_n = 1'b0;
    @(negedge clk);
    chk("sat_reset_cnt", llc_b, 0);
    chk("sat_reset_outs", {sys_b, cpu_b, ce32_b, ce8_b, ready_b}, 0);
    chk("sat_reset_main", {sys_reset_n, cpu_reset_n, ce_32m, ce_8m, ready, lock_loss_cnt}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
